// File: rtl/fwrisc_fetch.sv
// Instruction fetch: reads 32-bit words and assembles 16/32-bit instructions for decode.
// Compressed support (halfword buffer, FETCH2 straddle) is enabled by FWRISC_FETCH_COMPRESSED_EN.
module fwrisc_fetch (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:1] next_pc,
  input  logic        next_pc_seq,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  output logic        ivalid,
  input  logic        iready,
  output logic        fetch_valid,
  input  logic        decode_ready,
  output logic [31:0] instr,
  output logic        instr_c
);

  typedef enum logic [1:0] {FETCH1 = 2'd0, FETCH2 = 2'd1, VALID = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_c_q, instr_c_d;

`ifdef FWRISC_FETCH_COMPRESSED_EN
  logic [15:0] buf_hw_q, buf_hw_d;
  logic [31:2] buf_addr_q, buf_addr_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:1] fetch_pc_q, fetch_pc_d;
  logic        hit, buf_c;
  logic [31:2] pc_word_inc, fpc_word_inc;

  assign pc_word_inc  = next_pc[31:2] + 30'd1;
  assign fpc_word_inc = fetch_pc_q[31:2] + 30'd1;
  assign hit   = next_pc_seq && buf_valid_q && next_pc[1] && (buf_addr_q == next_pc[31:2]);
  assign buf_c = (buf_hw_q[1:0] != 2'b11);
`else
  logic unused_inputs;
  assign unused_inputs = ^{next_pc[1], next_pc_seq};
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH1;
      instr_q     <= 32'h0;
      instr_c_q   <= 1'b0;
`ifdef FWRISC_FETCH_COMPRESSED_EN
      buf_hw_q    <= 16'h0;
      buf_addr_q  <= 30'h0;
      buf_valid_q <= 1'b0;
      fetch_pc_q  <= 31'h0;
`endif
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      instr_c_q   <= instr_c_d;
`ifdef FWRISC_FETCH_COMPRESSED_EN
      buf_hw_q    <= buf_hw_d;
      buf_addr_q  <= buf_addr_d;
      buf_valid_q <= buf_valid_d;
      fetch_pc_q  <= fetch_pc_d;
`endif
    end
  end

`ifdef FWRISC_FETCH_COMPRESSED_EN
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    instr_c_d   = instr_c_q;
    buf_hw_d    = buf_hw_q;
    buf_addr_d  = buf_addr_q;
    buf_valid_d = buf_valid_q;
    fetch_pc_d  = fetch_pc_q;
    case (state_q)
      FETCH1: begin
        if (!next_pc_seq) buf_valid_d = 1'b0;
        if (hit && buf_c) begin
          instr_d     = {16'h0, buf_hw_q};
          instr_c_d   = 1'b1;
          buf_valid_d = 1'b0;
          state_d     = VALID;
        end else if (hit) begin
          if (iready) begin
            instr_d     = {idata[15:0], buf_hw_q};
            instr_c_d   = 1'b0;
            buf_hw_d    = idata[31:16];
            buf_addr_d  = pc_word_inc;
            buf_valid_d = 1'b1;
            state_d     = VALID;
          end
        end else if (iready) begin
          fetch_pc_d = next_pc;
          if (!next_pc[1]) begin
            if (idata[1:0] != 2'b11) begin
              instr_d     = {16'h0, idata[15:0]};
              instr_c_d   = 1'b1;
              buf_hw_d    = idata[31:16];
              buf_addr_d  = next_pc[31:2];
              buf_valid_d = 1'b1;
            end else begin
              instr_d     = idata;
              instr_c_d   = 1'b0;
              buf_valid_d = 1'b0;
            end
            state_d = VALID;
          end else if (idata[17:16] != 2'b11) begin
            instr_d     = {16'h0, idata[31:16]};
            instr_c_d   = 1'b1;
            buf_valid_d = 1'b0;
            state_d     = VALID;
          end else begin
            // low half of a straddling instruction; upper half comes from the next word
            instr_d = {16'h0, idata[31:16]};
            state_d = FETCH2;
          end
        end
      end
      FETCH2: begin
        if (iready) begin
          instr_d     = {idata[15:0], instr_q[15:0]};
          instr_c_d   = 1'b0;
          buf_hw_d    = idata[31:16];
          buf_addr_d  = fpc_word_inc;
          buf_valid_d = 1'b1;
          state_d     = VALID;
        end
      end
      VALID:   if (decode_ready) state_d = FETCH1;
      default: state_d = FETCH1;
    endcase
  end
`else
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    instr_c_d = instr_c_q;
    case (state_q)
      FETCH1: begin
        if (iready) begin
          instr_d   = idata;
          instr_c_d = 1'b0;
          state_d   = VALID;
        end
      end
      VALID:   if (decode_ready) state_d = FETCH1;
      default: state_d = FETCH1;
    endcase
  end
`endif

  always_comb begin
    ivalid = 1'b0;
    iaddr  = 32'h0;
    if (reset) begin
      case (state_q)
`ifdef FWRISC_FETCH_COMPRESSED_EN
        FETCH1: begin
          if (!(hit && buf_c)) begin
            ivalid = 1'b1;
            iaddr  = hit ? {pc_word_inc, 2'b00} : {next_pc[31:2], 2'b00};
          end
        end
        FETCH2: begin
          ivalid = 1'b1;
          iaddr  = {fpc_word_inc, 2'b00};
        end
`else
        FETCH1: begin
          ivalid = 1'b1;
          iaddr  = {next_pc[31:2], 2'b00};
        end
`endif
        default: ;
      endcase
    end
  end

  assign fetch_valid = (state_q == VALID);
  assign instr       = instr_q;
  assign instr_c     = instr_c_q;

endmodule

// File: tb/tb_fwrisc_fetch.sv
// Self-checking bench for fwrisc_fetch: instruction-level reference model plus directed cases.
// Follows FWRISC_FETCH_COMPRESSED_EN the same way the design does.
module tb_fwrisc_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:1] next_pc;
  logic        next_pc_seq;
  logic [31:0] iaddr, idata;
  logic        ivalid, iready;
  logic        fetch_valid, decode_ready;
  logic [31:0] instr;
  logic        instr_c;

  int checks = 0;
  int errors = 0;

`ifdef FWRISC_FETCH_COMPRESSED_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif

  logic [31:0] mem [16];
  assign idata = ivalid ? mem[iaddr[5:2]] : 32'hDEAD_BEEF;

  always #5 clock = ~clock;

  fwrisc_fetch dut (
    .clock(clock), .reset(reset), .next_pc(next_pc), .next_pc_seq(next_pc_seq),
    .iaddr(iaddr), .idata(idata), .ivalid(ivalid), .iready(iready),
    .fetch_valid(fetch_valid), .decode_ready(decode_ready),
    .instr(instr), .instr_c(instr_c)
  );

  // reference model state: which word's upper halfword is still unconsumed
  bit          buf_ok;
  logic [29:0] buf_word;
  logic [31:0] exp_instr;
  bit          exp_c;
  logic [31:0] exp_acc [$];
  bit          armed;

  logic [31:0] acc_q [$];
  int          stall_cnt;
  bit          prev_stall;
  logic [31:0] prev_addr;

  logic [31:0] got_instr;
  bit          got_c;
  int          got_lat;
  logic [31:0] got_acc [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] hw(input logic [30:0] p);
    logic [31:0] w;
    w = mem[p[4:1]];
    return p[0] ? w[31:16] : w[15:0];
  endfunction

  task automatic model_step(input logic [30:0] p, input bit seq);
    logic [30:0] pw, lasthw;
    logic [15:0] h0;
    logic [29:0] lw;
    bit c, hit;
    pw = CEN ? p : {p[30:1], 1'b0};
    if (!seq) buf_ok = 1'b0;
    h0 = hw(pw);
    c  = CEN && (h0[1:0] != 2'b11);
    exp_c     = c;
    exp_instr = c ? {16'h0, h0} : {hw(pw + 31'd1), h0};
    hit = CEN && seq && buf_ok && pw[0] && (buf_word == pw[30:1]);
    exp_acc.delete();
    if (hit) begin
      if (!c) exp_acc.push_back({pw[30:1] + 30'd1, 2'b00});
    end else begin
      exp_acc.push_back({pw[30:1], 2'b00});
      if (pw[0] && !c) exp_acc.push_back({pw[30:1] + 30'd1, 2'b00});
    end
    if (exp_acc.size() == 0) buf_ok = 1'b0;
    else begin
      lw     = exp_acc[exp_acc.size()-1][31:2];
      lasthw = c ? pw : pw + 31'd1;
      buf_ok = (lasthw != {lw, 1'b1});
      buf_word = lw;
    end
  endtask

  always @(negedge clock) begin
    if (!reset) prev_stall = 1'b0;
    else begin
      if (ivalid && iready) acc_q.push_back(iaddr);
      if (ivalid && !iready) stall_cnt++;
      if (prev_stall) begin
        chk("stall_ivalid", 32'(ivalid), 32'd1);
        chk("stall_iaddr", iaddr, prev_addr);
        chk("stall_fetch_valid", 32'(fetch_valid), 32'd0);
      end
      prev_stall = ivalid && !iready;
      prev_addr  = iaddr;
      if (fetch_valid && armed) begin
        chk("instr", instr, exp_instr);
        chk("instr_c", 32'(instr_c), 32'(exp_c));
        chk("valid_ivalid", 32'(ivalid), 32'd0);
      end
    end
  end

  function automatic bit pick(input int k, input int stall_n);
    if (stall_n < 0) return ($urandom_range(0, 3) != 0);
    return (k >= stall_n);
  endfunction

  // Entered with the DUT in FETCH1, just after a clock edge.
  task automatic do_instr(input logic [30:0] p, input bit seq, input int stall_n, input int hold);
    int  cyc, k;
    bit  done;
    model_step(p, seq);
    next_pc      = p;
    next_pc_seq  = seq;
    decode_ready = 1'b0;
    acc_q.delete();
    stall_cnt = 0;
    armed     = 1'b1;
    k = 0; cyc = 0; done = 1'b0;
    iready = pick(k, stall_n);
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (fetch_valid) begin done = 1'b1; break; end
      @(posedge clock); #1;
      cyc++; k++;
      iready       = pick(k, stall_n);
      decode_ready = 1'($urandom_range(0, 1));
    end
    decode_ready = 1'b0;
    if (!done) chk("fetch_timeout", 32'd0, 32'd1);
    got_instr = instr;
    got_c     = instr_c;
    got_lat   = cyc;
    got_acc   = acc_q;
    chk("latency", cyc, ((exp_acc.size() > 0) ? exp_acc.size() : 1) + stall_cnt);
    chk("bus_count", acc_q.size(), exp_acc.size());
    for (int i = 0; i < acc_q.size() && i < exp_acc.size(); i++)
      chk("bus_addr", acc_q[i], exp_acc[i]);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("hold_fetch_valid", 32'(fetch_valid), 32'd1);
    end
    decode_ready = 1'b1;
    @(posedge clock); #1;
    decode_ready = 1'b0;
    armed = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [30:0] p;
    bit seq;
    reset = 1'b0; next_pc = '0; next_pc_seq = 1'b0; iready = 1'b0; decode_ready = 1'b0;
    armed = 1'b0; buf_ok = 1'b0; buf_word = '0;
    mem[0] = 32'h63010000; mem[1] = 32'h00376301; mem[2] = 32'h00376301; mem[3] = 32'h63010000;
    for (int i = 4; i < 16; i++) mem[i] = 32'h0;
    #2;
    iready = 1'b1;
    #1;
    chk("rst_ivalid", 32'(ivalid), 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_c", 32'(instr_c), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;

`ifdef FWRISC_FETCH_COMPRESSED_EN
    do_instr(31'd0, 1'b1, 0, 0);
    chk("lit_model0", exp_instr, 32'h0);
    chk("lit_instr0", got_instr, 32'h0);
    chk("lit_c0", 32'(got_c), 32'd1);
    chk("lit_nacc0", got_acc.size(), 32'd1);
    if (got_acc.size() > 0) chk("lit_addr0", got_acc[0], 32'd0);
    do_instr(31'd1, 1'b1, 0, 0);
    chk("lit_instr1", got_instr, 32'h00006301);
    chk("lit_c1", 32'(got_c), 32'd1);
    chk("lit_nacc1", got_acc.size(), 32'd0);
    chk("lit_lat1", got_lat, 32'd1);
    do_instr(31'd2, 1'b1, 0, 0);
    chk("lit_instr2", got_instr, 32'h00006301);
    if (got_acc.size() > 0) chk("lit_addr2", got_acc[0], 32'd4);
    do_instr(31'd3, 1'b1, 3, 0);
    chk("lit_model3", exp_instr, 32'h63010037);
    chk("lit_instr3", got_instr, 32'h63010037);
    chk("lit_c3", 32'(got_c), 32'd0);
    chk("lit_nacc3", got_acc.size(), 32'd1);
    if (got_acc.size() > 0) chk("lit_addr3", got_acc[0], 32'd8);
    chk("lit_lat3", got_lat, 32'd4);
    do_instr(31'd0, 1'b0, 0, 0);
    do_instr(31'd1, 1'b0, 0, 5);
    chk("lit_br_instr", got_instr, 32'h00006301);
    chk("lit_br_nacc", got_acc.size(), 32'd1);
    if (got_acc.size() > 0) chk("lit_br_addr", got_acc[0], 32'd0);

    // reset while the second beat of a straddle is pending
    next_pc = 31'd3; next_pc_seq = 1'b0; iready = 1'b1; decode_ready = 1'b0;
    @(posedge clock); #1;
    iready = 1'b0;
    @(negedge clock);
    chk("f2_ivalid", 32'(ivalid), 32'd1);
    chk("f2_iaddr", iaddr, 32'd8);
    reset = 1'b0;
    #1;
    chk("f2rst_ivalid", 32'(ivalid), 32'd0);
    chk("f2rst_iaddr", iaddr, 32'd0);
    chk("f2rst_fetch_valid", 32'(fetch_valid), 32'd0);
    buf_ok = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    do_instr(31'd3, 1'b1, 0, 0);
    chk("lit_postrst_nacc", got_acc.size(), 32'd2);
    if (got_acc.size() > 0) chk("lit_postrst_addr", got_acc[0], 32'd4);
    chk("lit_postrst_instr", got_instr, 32'h63010037);

    mem[15] = 32'h00370000;
    do_instr(31'h7FFFFFFF, 1'b0, 0, 0);
    chk("lit_wrap_instr", got_instr, 32'h00000037);
    chk("lit_wrap_nacc", got_acc.size(), 32'd2);
    if (got_acc.size() > 1) chk("lit_wrap_addr", got_acc[1], 32'd0);
`else
    do_instr(31'd2, 1'b0, 0, 0);
    chk("lit_nc_instr", got_instr, 32'h00376301);
    chk("lit_nc_c", 32'(got_c), 32'd0);
    chk("lit_nc_lat", got_lat, 32'd1);
    if (got_acc.size() > 0) chk("lit_nc_addr", got_acc[0], 32'd4);
    do_instr(31'd1, 1'b1, 0, 0);
    chk("lit_nc_instr1", got_instr, 32'h63010000);
    if (got_acc.size() > 0) chk("lit_nc_addr1", got_acc[0], 32'd0);
    do_instr(31'd7, 1'b1, 0, 2);
    chk("lit_nc_instr7", got_instr, 32'h63010000);
    if (got_acc.size() > 0) chk("lit_nc_addr7", got_acc[0], 32'd12);
`endif

    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    p   = 31'($urandom_range(0, 40));
    seq = 1'b0;
    for (int n = 0; n < 300; n++) begin
      do_instr(p, seq, -1, $urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        p   = p + (exp_c ? 31'd1 : 31'd2);
        seq = 1'b1;
      end else begin
        seq = 1'b0;
        if ($urandom_range(0, 7) == 0) p = 31'h7FFFFFFC + 31'($urandom_range(0, 3));
        else p = 31'($urandom_range(0, 40));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
